// File: rtl/tf530_bus_pkg.sv
// tf530_bus_pkg: shared bus definitions for the fastram burst sequencer (state encoding, burst default, active-low levels).
package tf530_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, BEAT, HOLD} state_t;
    localparam int BURST_BEATS_DEF = 4;
    localparam logic ASSERTED = 1'b0;
    localparam logic NEGATED  = 1'b1;
endpackage

// File: rtl/fastram_burst_ctrl_if.sv
// fastram_burst_ctrl_if: 68030/decoder side and SRAM strobe side of the fastram burst sequencer.
interface fastram_burst_ctrl_if;
    logic       AS20, RW20, RAM_SEL, CBREQ, CBACK, STERM, RAMOE;
    logic [1:0] A, RAMA;
    logic [3:0] RAMCS_IN, RAMCS;
    modport master (output AS20, RW20, A, RAM_SEL, RAMCS_IN, CBREQ, input CBACK, STERM, RAMCS, RAMOE, RAMA);
    modport slave  (input AS20, RW20, A, RAM_SEL, RAMCS_IN, CBREQ, output CBACK, STERM, RAMCS, RAMOE, RAMA);
endinterface

// File: rtl/burst_wrap_ctr.sv
// burst_wrap_ctr: burst beat address with wrap inside the line plus last-beat flag.
// Only built with FASTRAM_BURST_EN; single-beat builds have no beat counter.
`ifdef FASTRAM_BURST_EN
module burst_wrap_ctr import tf530_bus_pkg::*; #(
    parameter int BURST_BEATS = BURST_BEATS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       inc,
    input  logic [1:0] a_in,
    output logic [1:0] addr,
    output logic       last
);
    localparam int NW = $clog2(BURST_BEATS);
    localparam logic [1:0] M = 2'(BURST_BEATS - 1);
    logic [1:0]    a;
    logic [NW-1:0] n;
    always_ff @(posedge clk)
        if (rst) begin
            a <= '0;
            n <= '0;
        end else if (load) begin
            a <= a_in;
            n <= '0;
        end else if (inc)
            n <= n + 1'b1;
    // bits above the burst size hold the starting value; only the low bits wrap
    assign addr = (a & ~M) | ((a + 2'(n)) & M);
    assign last = n == NW'(BURST_BEATS - 1);
endmodule
`endif

// File: rtl/fastram_burst_ctrl.sv
// fastram_burst_ctrl: turns the fastram decoder select into SRAM strobes and 68030 STERM/CBACK.
// Define FASTRAM_BURST_EN for cache-line burst fills; otherwise every cycle is single-beat.
module fastram_burst_ctrl import tf530_bus_pkg::*; #(
    parameter int WAIT_STATES = 1,
    parameter int BURST_BEATS = BURST_BEATS_DEF
) (
    input logic CLKCPU,
    input logic RESET,
    fastram_burst_ctrl_if.slave bus
);
    state_t     state;
    logic [2:0] wcnt;
    logic       more;
    always_ff @(posedge CLKCPU)
        if (RESET || bus.AS20 == NEGATED) begin
            state     <= IDLE;
            wcnt      <= '0;
            bus.STERM <= NEGATED;
            bus.RAMCS <= 4'hF;
            bus.RAMOE <= NEGATED;
        end else
            case (state)
                IDLE: if (bus.RAM_SEL == ASSERTED) begin
                    state     <= WAIT_STATES == 0 ? BEAT : WAIT;
                    bus.RAMCS <= bus.RW20 ? 4'h0 : bus.RAMCS_IN;
                    bus.RAMOE <= ~bus.RW20;
                end
                WAIT: begin
                    state <= wcnt == 3'(WAIT_STATES - 1) ? BEAT : WAIT;
                    wcnt  <= wcnt + 1'b1;
                end
                BEAT: begin
                    state     <= more ? BEAT : HOLD;
                    bus.STERM <= ASSERTED;
                end
                HOLD: bus.STERM <= NEGATED;
            endcase
`ifdef FASTRAM_BURST_EN
    logic       brq, stop, last, cback, idle, beat;
    logic [1:0] addr, rama;
    assign idle = state == IDLE;
    assign beat = state == BEAT;
    burst_wrap_ctr #(.BURST_BEATS(BURST_BEATS)) u_ctr (
        .clk(CLKCPU), .rst(RESET), .load(idle || bus.AS20), .inc(beat),
        .a_in(bus.A), .addr(addr), .last(last)
    );
    // a CBREQ negation seen on one beat makes the following beat the final one
    assign more = brq & ~last & ~stop;
    always_ff @(posedge CLKCPU)
        if (RESET || bus.AS20 || idle) begin
            brq   <= ~RESET & ~bus.CBREQ & bus.RW20;
            stop  <= 1'b0;
            cback <= NEGATED;
            rama  <= bus.A;
        end else if (beat) begin
            cback <= ~more;
            rama  <= addr;
            stop  <= stop | bus.CBREQ;
        end
    assign bus.CBACK = cback;
    assign bus.RAMA  = rama;
`else
    assign more      = 1'b0;
    assign bus.CBACK = NEGATED;
    assign bus.RAMA  = bus.A;
`endif
endmodule

// File: tb/tb_fastram_burst_ctrl.sv
// tb_fastram_burst_ctrl: directed checks of single, burst, write, abort and non-RAM cycles.
module tb_fastram_burst_ctrl;
`ifdef FASTRAM_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif
    logic CLKCPU = 1'b0;
    logic RESET  = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    int   pulses;
    int   lows;
    fastram_burst_ctrl_if bus();
    fastram_burst_ctrl #(.WAIT_STATES(1), .BURST_BEATS(4)) dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .bus(bus)
    );
    always #5 CLKCPU = ~CLKCPU;

    task automatic tick();
        @(posedge CLKCPU);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_sterm"}, bus.STERM, 1'b1);
        chk1({tag, "_cback"}, bus.CBACK, 1'b1);
        chk4({tag, "_ramcs"}, bus.RAMCS, 4'hF);
        chk1({tag, "_ramoe"}, bus.RAMOE, 1'b1);
    endtask

    task automatic start(input logic rw, input logic [1:0] a, input logic [3:0] cs, input logic cbreq);
        bus.RW20 = rw;
        bus.A = a;
        bus.RAMCS_IN = cs;
        bus.CBREQ = cbreq;
        bus.RAM_SEL = 1'b0;
        bus.AS20 = 1'b0;
    endtask

    task automatic finish_cycle();
        bus.AS20 = 1'b1;
        bus.RAM_SEL = 1'b1;
        bus.CBREQ = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        bus.AS20 = 1'b1; bus.RW20 = 1'b1; bus.A = 2'd2; bus.RAM_SEL = 1'b1;
        bus.RAMCS_IN = 4'hF; bus.CBREQ = 1'b1;
        tick(); tick();
        chk_idle("reset");
        chk4("reset_rama", 4'(bus.RAMA), 4'd2);
        RESET = 1'b0;
        tick();
        // single read, A=1, no burst request
        start(1'b1, 2'd1, 4'hF, 1'b1);
        tick();
        chk1("t1_ramoe_e1", bus.RAMOE, 1'b0);
        chk4("t1_ramcs_e1", bus.RAMCS, 4'h0);
        chk1("t1_sterm_e1", bus.STERM, 1'b1);
        tick();
        chk1("t1_sterm_e2", bus.STERM, 1'b1);
        tick();
        chk1("t1_sterm_e3", bus.STERM, 1'b0);
        chk1("t1_cback_e3", bus.CBACK, 1'b1);
        chk4("t1_rama_e3", 4'(bus.RAMA), 4'd1);
        tick();
        chk1("t1_sterm_e4", bus.STERM, 1'b1);
        chk1("t1_ramoe_hold", bus.RAMOE, 1'b0);
        bus.AS20 = 1'b1;
        tick();
        chk_idle("t1_end");
        finish_cycle();
        // burst read from A=2
        start(1'b1, 2'd2, 4'hF, 1'b0);
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1($sformatf("t2_sterm_b%0d", k), bus.STERM, (BURST_ON || k == 0) ? 1'b0 : 1'b1);
            chk1($sformatf("t2_cback_b%0d", k), bus.CBACK, (BURST_ON && k < 3) ? 1'b0 : 1'b1);
            chk4($sformatf("t2_rama_b%0d", k), 4'(bus.RAMA), BURST_ON ? 4'((2 + k) % 4) : 4'd2);
        end
        tick();
        chk1("t2_sterm_after", bus.STERM, 1'b1);
        chk1("t2_cback_after", bus.CBACK, 1'b1);
        finish_cycle();
        // burst with CBREQ negated, seen at the second beat
        start(1'b1, 2'd0, 4'hF, 1'b0);
        pulses = 0;
        tick(); tick(); tick();
        if (bus.STERM === 1'b0) pulses++;
        chk1("t3_cback_b1", bus.CBACK, BURST_ON ? 1'b0 : 1'b1);
        bus.CBREQ = 1'b1;
        tick();
        if (bus.STERM === 1'b0) pulses++;
        chk1("t3_cback_b2", bus.CBACK, BURST_ON ? 1'b0 : 1'b1);
        tick();
        if (bus.STERM === 1'b0) pulses++;
        chk1("t3_sterm_b3", bus.STERM, BURST_ON ? 1'b0 : 1'b1);
        chk1("t3_cback_b3", bus.CBACK, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.STERM === 1'b0) pulses++;
        end
        chk4("t3_pulses", 4'(pulses), BURST_ON ? 4'd3 : 4'd1);
        finish_cycle();
        // write with burst request: never bursts
        start(1'b0, 2'd3, 4'b1100, 1'b0);
        pulses = 0;
        lows = 0;
        tick();
        chk4("t4_ramcs", bus.RAMCS, 4'b1100);
        chk1("t4_ramoe", bus.RAMOE, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (bus.STERM === 1'b0) pulses++;
            if (bus.CBACK !== 1'b1 || bus.RAMOE !== 1'b1) lows++;
            tick();
        end
        chk4("t4_pulses", 4'(pulses), 4'd1);
        chk4("t4_cback_ramoe_low", 4'(lows), 4'd0);
        chk4("t4_ramcs_hold", bus.RAMCS, 4'b1100);
        finish_cycle();
        // AS20 raised during beat 2
        start(1'b1, 2'd1, 4'hF, 1'b0);
        tick(); tick(); tick(); tick();
        chk1("t5a_cback_b2", bus.CBACK, BURST_ON ? 1'b0 : 1'b1);
        bus.AS20 = 1'b1;
        bus.A = 2'd3;
        tick();
        chk_idle("t5a_abort");
        chk4("t5a_rama", 4'(bus.RAMA), 4'd3);
        finish_cycle();
        // RESET mid-burst
        start(1'b1, 2'd2, 4'hF, 1'b0);
        tick(); tick(); tick(); tick();
        chk1("t5b_sterm_b2", bus.STERM, BURST_ON ? 1'b0 : 1'b1);
        RESET = 1'b1;
        tick();
        chk_idle("t5b_reset");
        chk4("t5b_rama", 4'(bus.RAMA), 4'd2);
        RESET = 1'b0;
        finish_cycle();
        // non-RAM cycle: another slave terminates
        bus.AS20 = 1'b0; bus.RAM_SEL = 1'b1; bus.RW20 = 1'b1; bus.CBREQ = 1'b0;
        lows = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.STERM !== 1'b1 || bus.CBACK !== 1'b1 || bus.RAMOE !== 1'b1 || bus.RAMCS !== 4'hF) lows++;
        end
        chk4("t6_nonram_strobes", 4'(lows), 4'd0);
        finish_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
